// File: rtl/calc2_sched.sv
// calc2_sched: four-port request FIFOs, round-robin grant to one shared calc2 ALU.
// Define CALC2_SCHED_TIMEOUT_EN to build the WAIT-state ALU watchdog (TIMEOUT cycles).
module calc2_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [1:0]  req1_tag_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [1:0]  req2_tag_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [1:0]  req3_tag_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  input  logic [1:0]  req4_tag_in,
  output logic        req1_busy,
  output logic        req2_busy,
  output logic        req3_busy,
  output logic        req4_busy,
  output logic [1:0]  out_resp1,
  output logic [31:0] out_data1,
  output logic [1:0]  out_tag1,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data2,
  output logic [1:0]  out_tag2,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data3,
  output logic [1:0]  out_tag3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data4,
  output logic [1:0]  out_tag4,
  output logic        alu_valid,
  input  logic        alu_ready,
  output logic [3:0]  alu_cmd,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  input  logic        alu_err,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [3:0]  w_cmd_in  [4];
  logic [31:0] w_data_in [4];
  logic [1:0]  w_tag_in  [4];

  assign w_cmd_in[0]  = req1_cmd_in;
  assign w_cmd_in[1]  = req2_cmd_in;
  assign w_cmd_in[2]  = req3_cmd_in;
  assign w_cmd_in[3]  = req4_cmd_in;
  assign w_data_in[0] = req1_data_in;
  assign w_data_in[1] = req2_data_in;
  assign w_data_in[2] = req3_data_in;
  assign w_data_in[3] = req4_data_in;
  assign w_tag_in[0]  = req1_tag_in;
  assign w_tag_in[1]  = req2_tag_in;
  assign w_tag_in[2]  = req3_tag_in;
  assign w_tag_in[3]  = req4_tag_in;

  logic [3:0]  r_phase;
  logic [3:0]  r_ccmd [4];
  logic [1:0]  r_ctag [4];
  logic [31:0] r_cop1 [4];
  logic [69:0] r_mem  [4][DEPTH];
  logic [AW-1:0] r_wp [4];
  logic [AW-1:0] r_rp [4];
  logic [AW:0] r_cnt  [4];
  logic [3:0]  r_busy;
  logic [7:0]  r_drop;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_gnt;
  logic [3:0]  r_cmd;
  logic [1:0]  r_tag;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [1:0]  r_resp;
  logic [31:0] r_data;

  logic [3:0]  w_req;
  logic [3:0]  w_start;
  logic [3:0]  w_drop;
  logic [3:0]  w_pop;
  logic [3:0]  w_nonempty;
  logic [AW:0] w_cnt_nxt [4];
  logic [8:0]  w_drop_sum;
  logic        w_found;
  logic [1:0]  w_sel;
  logic [1:0]  w_idx;
  logic [69:0] w_entry;
  logic        w_ok;
  logic        w_grant;
  logic        w_done;
  logic        w_timeout;

  always_comb begin
    w_req      = '0;
    w_start    = '0;
    w_drop     = '0;
    w_nonempty = '0;
    for (int p = 0; p < 4; p++) begin
      w_req[p]      = !r_phase[p] && (w_cmd_in[p] != 4'd0);
      w_start[p]    = w_req[p] && (r_cnt[p] != FULL);
      w_drop[p]     = w_req[p] && (r_cnt[p] == FULL);
      w_nonempty[p] = (r_cnt[p] != '0);
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      w_cnt_nxt[p] = r_cnt[p] + (AW+1)'(r_phase[p])
                   - (AW+1)'(w_pop[p]);
    end
  end

  assign w_drop_sum = {1'b0, r_drop} + 9'(w_drop[0])
                    + 9'(w_drop[1]) + 9'(w_drop[2])
                    + 9'(w_drop[3]);

  // r_phase marks the op2 cycle; the entry enqueues at its end
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
      r_busy  <= '0;
      r_drop  <= '0;
      for (int p = 0; p < 4; p++) begin
        r_ccmd[p] <= '0;
        r_ctag[p] <= '0;
        r_cop1[p] <= '0;
        r_wp[p]   <= '0;
        r_rp[p]   <= '0;
        r_cnt[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (w_start[p]) begin
          r_phase[p] <= 1'b1;
          r_ccmd[p]  <= w_cmd_in[p];
          r_ctag[p]  <= w_tag_in[p];
          r_cop1[p]  <= w_data_in[p];
        end else begin
          r_phase[p] <= 1'b0;
        end
        if (r_phase[p]) r_wp[p] <= r_wp[p] + AW'(1);
        if (w_pop[p])   r_rp[p] <= r_rp[p] + AW'(1);
        r_cnt[p]  <= w_cnt_nxt[p];
        r_busy[p] <= (w_cnt_nxt[p] == FULL);
      end
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  always_ff @(posedge c_clk) begin
    for (int p = 0; p < 4; p++) begin
      if (r_phase[p]) begin
        r_mem[p][r_wp[p]] <= {r_ccmd[p], r_ctag[p],
                              r_cop1[p], w_data_in[p]};
      end
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && w_nonempty[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_entry = r_mem[w_sel][r_rp[w_sel]];

  always_comb begin
    w_ok = 1'b0;
    unique case (w_entry[69:66])
      4'd1, 4'd2, 4'd5, 4'd6: w_ok = 1'b1;
      default:                w_ok = 1'b0;
    endcase
  end

`ifdef CALC2_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_to;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_to <= '0;
    end else if (r_state == S_WAIT) begin
      r_to <= r_to + TW'(1);
    end else begin
      r_to <= '0;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !alu_done
                  && (r_to == TO_LAST);
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT > 0);
  assign w_timeout   = 1'b0;
`endif

  assign w_grant = (r_state == S_IDLE) && w_found;
  assign w_done  = (r_state == S_WAIT) && alu_done;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_pop[w_sel] = 1'b1;
          w_state_nxt  = w_ok ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: if (alu_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (alu_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // invalid cmds and timeouts both leave resp=2/data=0 from the grant
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= '0;
      r_gnt  <= '0;
      r_cmd  <= '0;
      r_tag  <= '0;
      r_op1  <= '0;
      r_op2  <= '0;
      r_resp <= '0;
      r_data <= '0;
    end else begin
      unique case (1'b1)
        w_grant: begin
          r_gnt  <= w_sel;
          r_ptr  <= w_sel + 2'd1;
          r_cmd  <= w_entry[69:66];
          r_tag  <= w_entry[65:64];
          r_op1  <= w_entry[63:32];
          r_op2  <= w_entry[31:0];
          r_resp <= 2'd2;
          r_data <= '0;
        end
        w_done: begin
          r_resp <= alu_err ? 2'd2 : 2'd1;
          r_data <= alu_result;
        end
        w_timeout: begin
          r_resp <= 2'd2;
          r_data <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_valid = (r_state == S_ISSUE);
    alu_cmd   = alu_valid ? r_cmd : 4'd0;
    alu_op1   = alu_valid ? r_op1 : 32'd0;
    alu_op2   = alu_valid ? r_op2 : 32'd0;
    out_resp1 = '0;
    out_data1 = '0;
    out_tag1  = '0;
    out_resp2 = '0;
    out_data2 = '0;
    out_tag2  = '0;
    out_resp3 = '0;
    out_data3 = '0;
    out_tag3  = '0;
    out_resp4 = '0;
    out_data4 = '0;
    out_tag4  = '0;
    if (r_state == S_RESP) begin
      unique case (r_gnt)
        2'd0: begin
          out_resp1 = r_resp;
          out_data1 = r_data;
          out_tag1  = r_tag;
        end
        2'd1: begin
          out_resp2 = r_resp;
          out_data2 = r_data;
          out_tag2  = r_tag;
        end
        2'd2: begin
          out_resp3 = r_resp;
          out_data3 = r_data;
          out_tag3  = r_tag;
        end
        default: begin
          out_resp4 = r_resp;
          out_data4 = r_data;
          out_tag4  = r_tag;
        end
      endcase
    end
  end

  assign req1_busy = r_busy[0];
  assign req2_busy = r_busy[1];
  assign req3_busy = r_busy[2];
  assign req4_busy = r_busy[3];
  assign drop_cnt  = r_drop;

endmodule

// File: doc/calc2_sched.md
# calc2_sched

Request scheduler in front of the shared calc2 ALU. Four requester ports use the calc2 two-cycle request protocol. Accepted requests are buffered per port, and one request at a time is granted round-robin to a single shared ALU. Each result is returned on the originating port with its tag unchanged.

## Interface
- `DEPTH`, default 4: per-port request FIFO depth in entries (power of two, ≥2).
- `TIMEOUT`, default 64: ALU watchdog limit in cycles; used only with `CALC2_SCHED_TIMEOUT_EN`.
- `c_clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `reqN_cmd_in` in 4: command for port N (N=1..4). 0 = idle; 1 add, 2 sub, 5 shl, 6 shr.
- `reqN_data_in` in 32: op1 in the cmd cycle, op2 in the following cycle.
- `reqN_tag_in` in 2: request tag, sampled in the cmd cycle.
- `reqN_busy` out 1: port N FIFO full; the requester must not start a command.
- `out_respN` out 2: 0 none, 1 success, 2 overflow/underflow/invalid/timeout.
- `out_dataN` out 32: result, valid when `out_respN`≠0.
- `out_tagN` out 2: tag of the responded request.
- `alu_valid` out 1: issue request to ALU.
- `alu_ready` in 1: ALU accepts the issue when high with `alu_valid`.
- `alu_cmd` out 4, `alu_op1` out 32, `alu_op2` out 32: issued operation.
- `alu_done` in 1: single-cycle pulse, result available.
- `alu_result` in 32: ALU result.
- `alu_err` in 1: overflow/underflow flag, qualified by `alu_done`.
- `drop_cnt` out 8: saturating count of requests dropped at full FIFOs.

## Operation
- **Capture, per port:** cmd≠0 in cycle T latches cmd, tag and op1. Cycle T+1 latches op2. The entry enqueues at the end of T+1. The cmd value in T+1 is ignored.
- **Drop on full:** if the FIFO is full in cycle T, the request is dropped. `drop_cnt` increments (saturates at 255), op2 is not captured, and no response is ever produced.
- **Simultaneous push and pop:** enqueue and pop on the same FIFO in the same cycle is legal; occupancy is unchanged.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any FIFO is non-empty, grant round-robin, pop the entry into the issue registers, then:
    - valid cmd → ISSUE;
    - invalid cmd (not 1/2/5/6) → RESP with resp=2, data=0.
  - ISSUE: `alu_valid`=1 with `alu_cmd`/`alu_op1`/`alu_op2` held stable. When `alu_ready`=1 → WAIT.
  - WAIT: `alu_done` captures `alu_result`; resp=2 if `alu_err`, else 1. → RESP.
  - RESP: drive `out_respN`/`out_dataN`/`out_tagN` on the granted port for exactly one cycle; all other ports read 0. → IDLE.
- **Round-robin:** pointer resets to port 1. After granting port k, the pointer moves to port k+1 (4 wraps to 1). The search starts at the pointer.
- **Outstanding ops:** at most one request is in the ALU at a time. The tag passes through unmodified; data is not transformed.
- **Spurious done:** `alu_done` outside WAIT is ignored.

## Timing
- **Reset values:** all outputs 0; state IDLE; FIFOs empty; capture phase cleared; pointer at port 1.
- **Reset mid-operation:** discards all queued and in-flight requests with no responses. A late `alu_done` after reset is ignored.
- **Minimum latency** (ALU ready immediately, done one cycle after acceptance):
  - T: cmd
  - T+1: op2
  - T+2: IDLE grant
  - T+3: ISSUE
  - T+4: WAIT/done
  - T+5: response valid
- **Throughput:** one response per 4 cycles maximum; an invalid cmd costs 2 cycles (IDLE, RESP).
- **Busy timing:** `reqN_busy` is registered and reflects occupancy==DEPTH after the current cycle's push/pop.

## Configuration
- **`CALC2_SCHED_TIMEOUT_EN` defined:** a counter runs in WAIT. If `alu_done` is absent for `TIMEOUT` cycles, go to RESP with resp=2, data=0, original tag. A later stray `alu_done` is ignored.
- **Undefined:** WAIT persists until `alu_done`; no counter is built.

## Test plan
- **Port 1 add:** cmd 1, op 0x56/0x103, tag 2, ALU ready and done +1 → `out_resp1`=1, `out_data1`=0x159, `out_tag1`=2 at T+5.
- **All four ports start sub the same cycle:** 0x158−0x12 each, tags 0..3 → responses on ports 1,2,3,4 in that order, each 0x146, 4 cycles apart.
- **Port 3 invalid cmd 4:** op 0x1/0x2 → `out_resp3`=2, `out_data3`=0, no `alu_valid` pulse.
- **Port 2 overfill:** hold `alu_ready`=0 and issue DEPTH+2 requests on port 2 → `req2_busy`=1 and `drop_cnt`=1. Then release `alu_ready` → exactly DEPTH+1 responses (1 in flight + DEPTH queued).
- **Reset mid-flight:** assert `reset` during WAIT with 2 entries queued → all outputs 0 immediately, no responses after release, `drop_cnt`=0.
- **Timeout (`CALC2_SCHED_TIMEOUT_EN`, TIMEOUT=8):** withhold `alu_done` → resp=2, data=0, correct tag after 8 WAIT cycles. A late `alu_done` produces no second response.
